demux7_reg: RTL and testbench
=============================

Name: demux7_reg

Overview:
- Registered 1-to-7 demultiplexer: the distributing counterpart of the 7-way result selector.
- Accepts one data word plus a 3-bit destination select over a valid/ready handshake and holds it in a one-entry output register.
- Presents the held word to exactly one of seven destination ports until that port accepts it.
- Used in the datapath to route a single producer (e.g. a multi-cycle unit result) to one of several consumers without combinational paths from input to output.

Parameters:
WIDTH, 8, data width of the input word and of each destination port.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer has a word and select this cycle.
in_ready  output  1  block accepts the word this cycle.
d  input  WIDTH  data word.
s  input  3  destination select: 3'b000..3'b110 select ports 0..6.
y0, y1, y2, y3, y4, y5, y6  output  WIDTH each  destination data ports.
y_valid  output  7  bit k set means yk carries a valid word.
y_ready  input  7  bit k set means destination k accepts this cycle.
bad_sel  output  1  sticky flag: a word was accepted with s == 3'b111.
busy  output  1  holding register occupied.

Behaviour:
- Reset: asynchronous, active-low; one clock; polarity and synchronicity fixed.
  - rst_n low forces state EMPTY, held data 0, held dest 0, bad_sel 0, immediately and without waiting for clk.
  - Hence y_valid = 0, all yk = 0, busy = 0, in_ready = 1 while in reset and after release.
- State machine, two states:
  - EMPTY: busy = 0.
  - FULL: busy = 1; holds hdata and hdest.
- Drain condition: drain = FULL && y_ready[hdest].
- in_ready = EMPTY || drain. This is a combinational function of state and y_ready only, never of in_valid.
- Accept: acc = in_valid && in_ready.
  - On acc, next cycle state is FULL with hdata = d and hdest = s.
  - s == 3'b111 is out of range: it maps to hdest = 3'b000, the same default as the selector, and sets bad_sel.
- Transitions:
  - EMPTY & acc -> FULL.
  - EMPTY & !acc -> EMPTY.
  - FULL & drain & acc -> FULL with the new word (back-to-back, no bubble).
  - FULL & drain & !acc -> EMPTY.
  - FULL & !drain -> FULL; hdata and hdest held stable.
- Outputs, driven only from registers:
  - y_valid[k] = FULL && (hdest == k).
  - yk = hdata when y_valid[k], else 0.
  - At most one y_valid bit is ever set.
- Latency and throughput:
  - A word accepted at edge N is visible on its port from the cycle after edge N.
  - Sustained throughput is 1 word per cycle while the addressed destinations are ready.
- Backpressure:
  - y_ready bits of non-addressed ports are ignored.
  - While FULL and the addressed port is not ready, in_ready = 0 and the word is held indefinitely.
- bad_sel: cleared only by reset; stays set through all later traffic.
- in_valid with in_ready = 0: no state change. The producer must hold d and s stable.
- Reset mid-transfer: the held word is discarded, no y_valid pulse is produced, and bad_sel clears.
- There is no combinational path from d, s or in_valid to any output.

Test Plan:
1. Reset release, then in_valid = 1, d = 8'hA5, s = 3'b011, y_ready = 7'h7F -> next cycle y_valid = 7'b0001000, y3 = 8'hA5, all other yk = 0; EMPTY the following cycle if no new input.
2. Back-to-back: words 8'h11/s = 0, 8'h22/s = 6, 8'h33/s = 2 on consecutive cycles, y_ready all 1 -> in_ready stays 1; y_valid = 0000001, 1000000, 0000100 on consecutive cycles with y0 = 11, y6 = 22, y2 = 33.
3. Backpressure: load 8'h5C to s = 4 with y_ready[4] = 0 for 3 cycles (other y_ready bits = 1) -> in_ready = 0 for those cycles, y4 held at 5C; raise y_ready[4] together with a new input 8'h77/s = 1 -> y4 drains and y1 = 77 on the next cycle, no bubble.
4. Out-of-range: d = 8'hEE, s = 3'b111 -> next cycle y0 = EE, y_valid = 0000001, bad_sel = 1; bad_sel stays 1 after further valid transfers.
5. Async reset while FULL and stalled (hold 8'h9D at s = 5, y_ready = 0), pulse rst_n low between clock edges -> y_valid = 0, y5 = 0, busy = 0, bad_sel = 0 immediately; in_ready = 1 after release.
6. Randomised: 1000 words with random s (including 3'b111) and random y_ready -> scoreboard confirms each word appears exactly once, in order, on the correct port (111 -> port 0), and y_valid is never multi-hot.

Source files
------------

// File: rtl/demux7_reg.sv
// demux7_reg: registered 1-to-7 demultiplexer with a valid/ready input and a one-entry output register
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready, d : producer handshake and data word
//   s                    : destination select; 3'b111 routes to port 0 and sets bad_sel
//   y0..y6, y_valid      : destination data ports and one-hot valid
//   y_ready              : per-destination accept
//   bad_sel              : sticky out-of-range select flag
//   busy                 : holding register occupied
module demux7_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [6:0]       y_valid,
  input  logic [6:0]       y_ready,
  output logic             bad_sel,
  output logic             busy
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] hdata_q, hdata_d;
  logic [2:0]       hdest_q, hdest_d;
  logic             bad_sel_q, bad_sel_d;
  logic             full, drain, acc;
  always_comb begin
    full      = state_q == FULL;
    drain     = full && y_ready[hdest_q];
    in_ready  = !full || drain;
    acc       = in_valid && in_ready;
    state_d   = acc ? FULL : (drain ? EMPTY : state_q);
    hdata_d   = acc ? d : hdata_q;
    hdest_d   = acc ? (s == 3'd7 ? 3'd0 : s) : hdest_q;
    bad_sel_d = bad_sel_q || (acc && s == 3'd7);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= EMPTY;
      hdata_q   <= '0;
      hdest_q   <= '0;
      bad_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdata_q   <= hdata_d;
      hdest_q   <= hdest_d;
      bad_sel_q <= bad_sel_d;
    end
  // hdest_q never holds 7, so the shifted one-hot always fits in 7 bits
  assign y_valid = full ? 7'(7'd1 << hdest_q) : 7'd0;
  assign y0      = y_valid[0] ? hdata_q : '0;
  assign y1      = y_valid[1] ? hdata_q : '0;
  assign y2      = y_valid[2] ? hdata_q : '0;
  assign y3      = y_valid[3] ? hdata_q : '0;
  assign y4      = y_valid[4] ? hdata_q : '0;
  assign y5      = y_valid[5] ? hdata_q : '0;
  assign y6      = y_valid[6] ? hdata_q : '0;
  assign bad_sel = bad_sel_q;
  assign busy    = full;
endmodule

// File: tb/tb_demux7_reg.sv
// tb_demux7_reg: self-checking bench for demux7_reg with directed scenarios and a randomised scoreboard
module tb_demux7_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] d = '0;
  logic [2:0] s = '0;
  logic [7:0] y [7];
  logic [6:0] y_valid;
  logic [6:0] y_ready = '0;
  logic       bad_sel;
  logic       busy;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {logic [7:0] data; int port;} w_t;
  demux7_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .s(s),
    .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]), .y4(y[4]), .y5(y[5]), .y6(y[6]),
    .y_valid(y_valid), .y_ready(y_ready), .bad_sel(bad_sel), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] y_or_except(input int k);
    logic [7:0] r = '0;
    for (int i = 0; i < 7; i++) if (i != k) r |= y[i];
    return r;
  endfunction
  task automatic drive(input logic v, input logic [7:0] dd, input logic [2:0] ss, input logic [6:0] rdy);
    @(negedge clk);
    in_valid = v; d = dd; s = ss; y_ready = rdy;
    #1;
  endtask
  task automatic test_reset;
    #2;
    n_checks += 5;
    if (y_valid !== 7'd0) begin n_fail++; $display("FAIL reset_y_valid got %b want 0000000", y_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (bad_sel !== 1'b0) begin n_fail++; $display("FAIL reset_bad_sel got %b want 0", bad_sel); end
    if (y_or_except(-1) !== 8'h00) begin n_fail++; $display("FAIL reset_y_zero got %h want 00", y_or_except(-1)); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release got rdy=%b busy=%b want 1 0", in_ready, busy); end
  endtask
  task automatic test_single;
    drive(1, 8'hA5, 3'd3, 7'h7F);
    drive(0, 8'h00, 3'd0, 7'h7F);
    n_checks += 3;
    if (y_valid !== 7'b0001000) begin n_fail++; $display("FAIL single_y_valid got %b want 0001000", y_valid); end
    if (y[3] !== 8'hA5) begin n_fail++; $display("FAIL single_y3 got %h want a5", y[3]); end
    if (y_or_except(3) !== 8'h00) begin n_fail++; $display("FAIL single_others got %h want 00", y_or_except(3)); end
    drive(0, 8'h00, 3'd0, 7'h7F);
    n_checks++;
    if (busy !== 1'b0 || y_valid !== 7'd0) begin n_fail++; $display("FAIL single_empty got busy=%b vld=%b want 0 0", busy, y_valid); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] dat [3] = '{8'h11, 8'h22, 8'h33};
    logic [2:0] sel [3] = '{3'd0, 3'd6, 3'd2};
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, i < 3 ? dat[i] : 8'h00, i < 3 ? sel[i] : 3'd0, 7'h7F);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
      if (i > 0) begin
        n_checks += 2;
        if (y_valid !== 7'(7'd1 << sel[i-1])) begin n_fail++; $display("FAIL b2b_y_valid[%0d] got %b want %b", i, y_valid, 7'(7'd1 << sel[i-1])); end
        if (y[sel[i-1]] !== dat[i-1]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, y[sel[i-1]], dat[i-1]); end
      end
    end
    drive(0, 8'h00, 3'd0, 7'h7F);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got busy=%b want 0", busy); end
  endtask
  task automatic test_backpressure;
    drive(1, 8'h5C, 3'd4, 7'h6F);
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 3'd0, 7'h6F);
      n_checks += 3;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      if (y[4] !== 8'h5C) begin n_fail++; $display("FAIL bp_hold[%0d] got %h want 5c", i, y[4]); end
      if (y_valid !== 7'b0010000) begin n_fail++; $display("FAIL bp_y_valid[%0d] got %b want 0010000", i, y_valid); end
    end
    drive(1, 8'h77, 3'd1, 7'h7F);
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    if (y[4] !== 8'h5C) begin n_fail++; $display("FAIL bp_release_y4 got %h want 5c", y[4]); end
    drive(0, 8'h00, 3'd0, 7'h7F);
    n_checks += 2;
    if (y_valid !== 7'b0000010) begin n_fail++; $display("FAIL bp_next_valid got %b want 0000010", y_valid); end
    if (y[1] !== 8'h77) begin n_fail++; $display("FAIL bp_next_y1 got %h want 77", y[1]); end
    drive(0, 8'h00, 3'd0, 7'h7F);
  endtask
  task automatic test_bad_sel;
    drive(1, 8'hEE, 3'd7, 7'h7F);
    drive(0, 8'h00, 3'd0, 7'h00);
    n_checks += 3;
    if (y_valid !== 7'b0000001) begin n_fail++; $display("FAIL bad_y_valid got %b want 0000001", y_valid); end
    if (y[0] !== 8'hEE) begin n_fail++; $display("FAIL bad_y0 got %h want ee", y[0]); end
    if (bad_sel !== 1'b1) begin n_fail++; $display("FAIL bad_flag got %b want 1", bad_sel); end
    drive(1, 8'h01, 3'd5, 7'h7F);
    drive(1, 8'h02, 3'd2, 7'h7F);
    drive(0, 8'h00, 3'd0, 7'h7F);
    drive(0, 8'h00, 3'd0, 7'h7F);
    n_checks++;
    if (bad_sel !== 1'b1) begin n_fail++; $display("FAIL bad_sticky got %b want 1", bad_sel); end
  endtask
  task automatic test_async_reset;
    drive(1, 8'h9D, 3'd5, 7'h00);
    drive(0, 8'h00, 3'd0, 7'h00);
    n_checks++;
    if (y[5] !== 8'h9D) begin n_fail++; $display("FAIL ar_loaded got %h want 9d", y[5]); end
    #1 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (y_valid !== 7'd0) begin n_fail++; $display("FAIL ar_y_valid got %b want 0000000", y_valid); end
    if (y[5] !== 8'h00) begin n_fail++; $display("FAIL ar_y5 got %h want 00", y[5]); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b want 0", busy); end
    if (bad_sel !== 1'b0) begin n_fail++; $display("FAIL ar_bad_sel got %b want 0", bad_sel); end
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready got %b want 1", in_ready); end
    drive(0, 8'h00, 3'd0, 7'h00);
    n_checks++;
    if (busy !== 1'b0 || y_valid !== 7'd0) begin n_fail++; $display("FAIL ar_no_pulse got busy=%b vld=%b want 0 0", busy, y_valid); end
  endtask
  task automatic test_random;
    w_t held [$];
    w_t sent [$];
    w_t w;
    int n_sent = 0, n_del = 0, cyc = 0;
    bit pend = 0;
    logic [7:0] pd = '0;
    int ps = 0;
    logic [6:0] exp_vld;
    logic exp_rdy;
    while (n_del < 1000 && cyc < 20000) begin
      cyc++;
      if (!pend && n_sent < 1000 && $urandom_range(3) != 0) begin
        pend = 1; pd = 8'($urandom); ps = $urandom_range(7);
      end
      drive(pend, pd, 3'(ps), 7'($urandom | $urandom));
      exp_vld = held.size() != 0 ? 7'(7'd1 << held[0].port) : 7'd0;
      exp_rdy = held.size() == 0 || y_ready[held[0].port];
      n_checks += 4;
      if (y_valid !== exp_vld) begin n_fail++; $display("FAIL rnd_y_valid cyc %0d got %b want %b", cyc, y_valid, exp_vld); end
      if ($countones(y_valid) > 1) begin n_fail++; $display("FAIL rnd_multihot cyc %0d got %b want at most one bit", cyc, y_valid); end
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy); end
      if (busy !== (held.size() != 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, held.size() != 0); end
      for (int k = 0; k < 7; k++) begin
        n_checks++;
        if (y[k] !== (exp_vld[k] ? held[0].data : 8'h00)) begin n_fail++; $display("FAIL rnd_y%0d cyc %0d got %h want %h", k, cyc, y[k], exp_vld[k] ? held[0].data : 8'h00); end
        if (y_valid[k] && y_ready[k]) begin
          n_checks++;
          if (n_del >= sent.size() || sent[n_del].port != k || sent[n_del].data !== y[k]) begin
            n_fail++; $display("FAIL rnd_order word %0d got port %0d data %h want port %0d data %h", n_del, k, y[k], n_del < sent.size() ? sent[n_del].port : -1, n_del < sent.size() ? sent[n_del].data : 8'h00);
          end
          n_del++;
        end
      end
      if (held.size() != 0 && y_ready[held[0].port]) void'(held.pop_front());
      if (pend && exp_rdy) begin
        w.data = pd; w.port = ps == 7 ? 0 : ps;
        held.push_back(w); sent.push_back(w);
        n_sent++; pend = 0;
      end
    end
    n_checks++;
    if (n_del != 1000 || n_sent != 1000) begin n_fail++; $display("FAIL rnd_count got sent %0d delivered %0d want 1000 1000", n_sent, n_del); end
    drive(0, 8'h00, 3'd0, 7'h00);
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_bad_sel;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
